// File: rtl/uart_trans.sv
// uart_trans: serial packet transmitter, one-period recSig announce, MSB-first data.
// Define UART_TRANS_QUEUE_EN to add a one-entry pending word register.
module uart_trans #(
  parameter int packetSize = 4,
  parameter int cycleDiv   = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [packetSize-1:0] dataIn,
  output logic                  ready,
  output logic                  busy,
  output logic                  recSig,
  output logic                  bsOut,
  output logic                  done
);
  localparam int CW = $clog2(cycleDiv);
  localparam int IW = $clog2(packetSize + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SIGNAL = 2'd1;
  localparam logic [1:0] LEAD   = 2'd2;
  localparam logic [1:0] SEND   = 2'd3;

  localparam logic [CW-1:0] LAST = CW'(cycleDiv - 1);
  localparam logic [IW-1:0] TOP  = IW'(packetSize - 1);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  lead2;
  logic [packetSize-1:0] sh;
  logic                  load;
  logic [packetSize-1:0] load_word;
  logic                  period_end;

  assign period_end = (cnt == LAST);

`ifdef UART_TRANS_QUEUE_EN
  logic                  pv;
  logic [packetSize-1:0] pend;

  assign ready     = ~pv;
  // a pending word wins over a fresh start on the done cycle
  assign load      = (state == IDLE) && (pv || start);
  assign load_word = pv ? pend : dataIn;

  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= 1'b0;
    end else if (state == IDLE && pv) begin
      pv <= 1'b0;
    end else if (state != IDLE && start && !pv) begin
      pv   <= 1'b1;
      pend <= dataIn;
    end
  end
`else
  assign ready     = ~busy;
  assign load      = (state == IDLE) && start;
  assign load_word = dataIn;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      lead2  <= 1'b0;
      busy   <= 1'b0;
      recSig <= 1'b0;
      bsOut  <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= period_end ? '0 : cnt + CW'(1);
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (load) begin
            sh     <= load_word;
            state  <= SIGNAL;
            busy   <= 1'b1;
            recSig <= 1'b1;
          end
        end
        SIGNAL: begin
          if (period_end) begin
            state  <= LEAD;
            recSig <= 1'b0;
            lead2  <= 1'b0;
          end
        end
        LEAD: begin
          if (period_end) begin
            lead2 <= 1'b1;
            if (lead2) begin
              state <= SEND;
              bsOut <= sh[packetSize-1];
              sh    <= sh << 1;
              idx   <= TOP;
            end
          end
        end
        SEND: begin
          if (period_end) begin
            if (idx == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
              bsOut <= 1'b1;
              done  <= 1'b1;
            end else begin
              bsOut <= sh[packetSize-1];
              sh    <= sh << 1;
              idx   <= idx - IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_trans.sv
// tb_uart_trans: scoreboard bench for uart_trans, with a loopback receiver model.
// Covers the default build and, if UART_TRANS_QUEUE_EN is defined, the pending word.
module tb_uart_trans;
  localparam int PS = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [PS-1:0] dataIn;
  logic          ready;
  logic          busy;
  logic          recSig;
  logic          bsOut;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PS-1:0] exp_q[$];
  logic [PS-1:0] exp_w;
  logic [PS-1:0] rx_word = '0;
  logic          rx_on = 1'b0;
  logic          prev_rec = 1'b0;
  int            rx_cnt = 0;

  uart_trans #(.packetSize(PS), .cycleDiv(D)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dataIn(dataIn),
    .ready(ready),
    .busy(busy),
    .recSig(recSig),
    .bsOut(bsOut),
    .done(done)
  );

  always #5 clk = ~clk;

  // expected {ready,busy,recSig,bsOut,done} r cycles after acceptance
  function automatic logic [4:0] pkt_exp(int r, logic [PS-1:0] w);
    logic b, rc, bs, dn, rd;
    b  = (r >= 1) && (r <= (3 + PS) * D);
    rc = (r >= 1) && (r <= D);
    bs = 1'b1;
    if (r >= 3 * D + 1 && r <= (3 + PS) * D)
      bs = w[PS - 1 - (r - 3 * D - 1) / D];
    dn = (r == (3 + PS) * D + 1);
`ifdef UART_TRANS_QUEUE_EN
    rd = 1'b1;
`else
    rd = ~b;
`endif
    return {rd, b, rc, bs, dn};
  endfunction

  // advance one clk, sample outputs, run receiver model and scoreboard
  task automatic step();
    @(posedge clk);
    #1;
    if (recSig && !prev_rec) begin
      rx_on  = 1'b1;
      rx_cnt = 0;
    end else if (rx_on) begin
      rx_cnt++;
    end
    if (rx_on && rx_cnt >= 3 * D && rx_cnt < (3 + PS) * D && rx_cnt % D == D / 2)
      rx_word = {rx_word[PS-2:0], bsOut};
    if (done) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected t=%0t got done=1 want no done", $time);
      end else begin
        exp_w = exp_q.pop_front();
        if (rx_word !== exp_w) begin
          n_fail++;
          $display("FAIL loopback t=%0t got %b want %b", $time, rx_word, exp_w);
        end
      end
      rx_on = 1'b0;
    end
    prev_rec = recSig;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b1;
    start = 1'b0;
    dataIn = '0;
    step();
    step();
    start = 1'b1;
    dataIn = 4'hF;
    step();
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      obs = {ready, busy, recSig, bsOut, done};
      n_tests++;
      if (obs !== 5'b10010) begin
        n_fail++;
        $display("FAIL reset c=%0d got %b want %b", c, obs, 5'b10010);
      end
    end
  endtask

  task automatic test_single();
    logic [4:0] obs, expv;
    for (int c = 1; c <= 35; c++) begin
      start = (c == 1);
      dataIn = 4'b1011;
      if (c == 1) exp_q.push_back(4'b1011);
      step();
      obs = {ready, busy, recSig, bsOut, done};
      expv = pkt_exp(c, 4'b1011);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL single c=%0d got %b want %b", c, obs, expv);
      end
    end
    start = 1'b0;
  endtask

`ifndef UART_TRANS_QUEUE_EN
  task automatic test_ignore();
    logic [4:0] obs, expv;
    for (int c = 1; c <= 60; c++) begin
      start = (c == 1) || (c == 11);
      if (c == 1) begin
        dataIn = 4'b1011;
        exp_q.push_back(4'b1011);
      end else if (c == 11) begin
        dataIn = 4'b0000;
      end else begin
        dataIn = PS'($urandom);
      end
      step();
      obs = {ready, busy, recSig, bsOut, done};
      expv = pkt_exp(c, 4'b1011);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL ignore c=%0d got %b want %b", c, obs, expv);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [PS-1:0] w[4] = '{4'hF, 4'h5, 4'h9, 4'h2};
    logic [4:0] obs, expv;
    int k;
    for (int c = 1; c <= 125; c++) begin
      start = (c - 1) <= 87;
      if ((c - 1) <= 87) dataIn = w[(c - 1) / 29];
      if ((c - 1) <= 87 && (c - 1) % 29 == 0) exp_q.push_back(w[(c - 1) / 29]);
      step();
      k = (c - 1) / 29;
      if (k > 3) k = 3;
      obs = {ready, busy, recSig, bsOut, done};
      expv = pkt_exp(c - 29 * k, w[k]);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL b2b c=%0d got %b want %b", c, obs, expv);
      end
    end
    start = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [4:0] obs, expv;
    for (int c = 1; c <= 55; c++) begin
      start = (c == 1) || (c == 21);
      reset = (c == 19);
      if (c == 1) begin
        dataIn = 4'b1011;
        exp_q.push_back(4'b1011);
      end
      if (c == 19) begin
        exp_q.delete();
        rx_on = 1'b0;
      end
      if (c == 21) begin
        dataIn = 4'b0110;
        exp_q.push_back(4'b0110);
      end
      step();
      if (c <= 18) expv = pkt_exp(c, 4'b1011);
      else if (c <= 20) expv = 5'b10010;
      else expv = pkt_exp(c - 20, 4'b0110);
      obs = {ready, busy, recSig, bsOut, done};
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL reset_mid c=%0d got %b want %b", c, obs, expv);
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

`ifdef UART_TRANS_QUEUE_EN
  task automatic test_queue();
    logic [4:0] obs, expv;
    for (int c = 1; c <= 65; c++) begin
      start = (c == 1) || (c == 4);
      if (c == 1) begin
        dataIn = 4'b1011;
        exp_q.push_back(4'b1011);
      end
      if (c == 4) begin
        dataIn = 4'b0110;
        exp_q.push_back(4'b0110);
      end
      step();
      if (c <= 29) expv = pkt_exp(c, 4'b1011);
      else expv = pkt_exp(c - 29, 4'b0110);
      if (c >= 4 && c <= 29) expv[4] = 1'b0;
      obs = {ready, busy, recSig, bsOut, done};
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL queue c=%0d got %b want %b", c, obs, expv);
      end
    end
    start = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dataIn = '0;
    test_reset();
    test_single();
`ifndef UART_TRANS_QUEUE_EN
    test_ignore();
`endif
    test_reset_mid();
`ifdef UART_TRANS_QUEUE_EN
    test_queue();
`else
    test_back_to_back();
`endif
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_done got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_trans.md
UART_TRANS -- requirements
Module: uart_trans

Interface
REQ-001 Parameter packetSize, default 4: number of data bits per packet; must be >= 1.
REQ-002 Parameter cycleDiv, default 100: clk cycles per serial bit period (sclk); must be >= 2.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to send dataIn; sampled every clk.
REQ-006 dataIn  input  packetSize  word to send; sampled only on an accepted start.
REQ-007 ready  output  1  high when a start this cycle will be accepted.
REQ-008 busy  output  1  high while a packet is in flight (SIGNAL, LEAD or SEND state).
REQ-009 recSig  output  1  announce line to the receiver; high for exactly one bit period per packet.
REQ-010 bsOut  output  1  serial data line to the receiver.
REQ-011 done  output  1  one-clk pulse after the last bit period of a packet.

Function
REQ-012 States: IDLE, SIGNAL, LEAD, SEND; registered outputs, Moore style.
REQ-013 Bit-period counter counts 0..cycleDiv-1; it clears to 0 on start acceptance and at every state change; a period ends when count==cycleDiv-1.
REQ-014 IDLE: ready=1, busy=0, recSig=0, bsOut=1.
REQ-015 start=1 in IDLE at cycle T: dataIn latched into shift register; state=SIGNAL from T+1.
REQ-016 SIGNAL: recSig=1, bsOut=1, busy=1, lasting one bit period (cycleDiv clks); then LEAD.
REQ-017 LEAD: recSig=0, bsOut=1, lasting two bit periods; first data bit begins exactly 3 bit periods after recSig rises, giving the receiver its 3-period start-up.
REQ-018 SEND: packetSize bit periods, MSB first; bsOut holds the current bit for the whole period; a bit index counter (width clog2(packetSize+1)) ends SEND after bit 0.
REQ-019 After the final SEND period: done=1 for one clk, busy=0, bsOut=1, state=IDLE in that same cycle.
REQ-020 Packet from start acceptance to done: (3+packetSize)*cycleDiv+1 clks.
REQ-021 Without queueing (REQ-027), start while busy is ignored and dataIn changes while busy have no effect on the packet in flight.
REQ-022 start held high continuously: a new packet is accepted on the cycle done is asserted, since ready=1 in IDLE.

Reset
REQ-023 reset=1 at any clk edge, including mid-packet: state=IDLE, counters=0, recSig=0, bsOut=1, busy=0, done=0, ready=1 on the following cycle.
REQ-024 A start coinciding with reset is dropped.
REQ-025 A packet truncated by reset produces no done pulse.
REQ-026 Shift register contents after reset are don't-care and not observable.

Configuration
REQ-027 Macro UART_TRANS_QUEUE_EN defined: adds a one-entry pending register; start while busy with the pending register empty captures dataIn there. ready=~pendingValid. On the done cycle a pending word loads directly into SIGNAL in the next cycle, with no IDLE cycle, and pendingValid clears. reset empties the register.
REQ-028 Macro UART_TRANS_QUEUE_EN undefined: no pending register; ready=~busy; behaviour per REQ-021.

Verification (packetSize=4, cycleDiv=4; start at cycle 0)
REQ-029 dataIn=4'b1011, single start pulse -> recSig=1 at cycles 1-4; bsOut=1 at cycles 5-12; bsOut=1,0,1,1 at cycles 13-16, 17-20, 21-24 and 25-28 respectively; done=1 only at cycle 29.
REQ-030 Second start at cycle 10 with dataIn=4'b0000, macro undefined -> ignored; bsOut matches REQ-029 and no second packet follows.
REQ-031 reset=1 at cycle 18 -> cycle 19 shows recSig=0, bsOut=1, busy=0; no done pulse; a new start at cycle 20 begins SIGNAL at cycle 21.
REQ-032 Macro defined: 4'b1011 at cycle 0, then 4'b0110 at cycle 3 -> ready=0 from cycle 4 until the done cycle; second SIGNAL at cycles 30-33; bits 0,1,1,0 at cycles 42-57; done pulses at cycles 29 and 58.
REQ-033 start held high with dataIn=4'b1111, macro undefined -> done every 29 clks; recSig rises at cycles 1, 30 and 59.
REQ-034 Back-to-back loopback into the 4-bit receiver -> the receiver's data output equals each sent word after each done.
